ram_port_arbiter: RTL

Two-requester arbiter that time-shares one single-port synchronous RAM (1-cycle registered read, read-before-write on the same edge). It grants at most one access per cycle, drives the RAM address/data/write-enable, and routes read data back to the requester that issued the read. It sits between two client blocks and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/ram_arb_pick.sv | 34 +++
 rtl/ram_port_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-requester RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned NREQ           = 2;
  localparam int unsigned DefDataWidth   = 8;
  localparam int unsigned DefAddrWidth   = 4;

  typedef logic req_id_t;

  // One requester's access at the default word/address widths.
  typedef struct packed {
    logic                    we;
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] wdata;
  } access_t;

  function automatic logic [NREQ-1:0] id_to_onehot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for the RAM port arbiter.
// RAM_ARB_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_id_t         last_gnt,
  output logic [NREQ-1:0] gnt,
  output req_id_t         win_id,
  output logic            any_gnt
);

  req_id_t pref_id;

`ifdef RAM_ARB_RR_EN
  assign pref_id = ~last_gnt;
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign pref_id         = 1'b0;
`endif

  always_comb begin
    any_gnt = |req;
    // Contention goes to the preferred requester; otherwise the lone requester wins.
    if (&req) begin
      win_id = pref_id;
    end else begin
      win_id = req[1];
    end
    gnt = any_gnt ? id_to_onehot(win_id) : '0;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Time-shares one single-port synchronous RAM between two requesters and routes read data back.
// Contention policy follows RAM_ARB_RR_EN (round-robin) or fixed priority when undefined.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NREQ       = ram_arb_pkg::NREQ
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ-1:0]                      we,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      addr,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]                      gnt,
  output logic [NREQ-1:0]                      rvalid,
  output logic [NREQ-1:0][DATA_WIDTH-1:0]      rdata,
  output logic                                 ram_we,
  output logic [ADDR_WIDTH-1:0]                ram_addr,
  output logic [DATA_WIDTH-1:0]                ram_din,
  input  logic [DATA_WIDTH-1:0]                ram_dout
);

  logic [NREQ-1:0]                 pick_gnt;
  req_id_t                         win_id;
  logic                            any_gnt;
  req_id_t                         last_gnt_q;
  logic                            tag_valid_q;
  req_id_t                         tag_id_q;
  logic [NREQ-1:0]                 rvalid_q;
  logic [NREQ-1:0][DATA_WIDTH-1:0] rdata_q;

  ram_arb_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .win_id   (win_id),
    .any_gnt  (any_gnt)
  );

  assign gnt    = pick_gnt;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (any_gnt) begin
      ram_we   = we[win_id];
      ram_addr = addr[win_id];
      ram_din  = wdata[win_id];
    end
  end

  // Tag stage tracks which requester owns the read data the RAM returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_id_q    <= 1'b0;
    end else begin
      tag_valid_q <= any_gnt & ~we[win_id];
      if (any_gnt) begin
        last_gnt_q <= win_id;
        tag_id_q   <= win_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (tag_valid_q) begin
        rvalid_q[tag_id_q] <= 1'b1;
        rdata_q[tag_id_q]  <= ram_dout;
      end
    end
  end

endmodule
